ita_mask_gen: RTL



---
 rtl/ita_mask_gen_pkg.sv | 46 ++++
 rtl/ita_mask_mod.sv | 69 ++++++
 rtl/ita_mask_gen.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ita_mask_gen_pkg.sv
// Shared types for the attention-mask generator: mode encoding, FSM states, config word
// and the compare-subtract modular add used by the residue logic.
package ita_mask_gen_pkg;

    localparam int unsigned MaskM        = 64;
    localparam int unsigned MaskMaxTiles = 16;
    localparam int unsigned MaskIdxW     = $clog2(MaskM * MaskMaxTiles) + 1;

    localparam int unsigned OffsetW = MaskIdxW;
    localparam int unsigned StrideW = MaskIdxW;
    localparam int unsigned WindowW = MaskIdxW;
    localparam int unsigned TileW   = $clog2(MaskMaxTiles) + 1;

    typedef enum logic [2:0] {
        MaskNone,
        MaskCausal,
        MaskAntiCausal,
        MaskStrided,
        MaskWindow,
        MaskStridedWindow
    } mask_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StRun
    } mask_state_e;

    typedef struct packed {
        mask_mode_e                 mode;
        logic signed [OffsetW-1:0]  offset;
        logic [StrideW-1:0]         stride;
        logic [WindowW-1:0]         window;
        logic [TileW-1:0]           tile_s;
    } mask_cfg_t;

    // Operands are already reduced below s, so a single compare-subtract suffices.
    function automatic logic [MaskIdxW-1:0] mod_add(input logic [MaskIdxW-1:0] a,
                                                    input logic [MaskIdxW-1:0] b,
                                                    input logic [MaskIdxW-1:0] s);
        logic [MaskIdxW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, s}) ? MaskIdxW'(sum - {1'b0, s}) : MaskIdxW'(sum);
    endfunction

endpackage

// File: rtl/ita_mask_mod.sv
// Serial restoring remainder: dividend mod divisor, one quotient bit per cycle, W cycles.
// done_o flags the final step; rem_o carries that step's result combinationally.
module ita_mask_mod #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         done_o,
    output logic [W-1:0] rem_o
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W:0]      trial;
    logic [W-1:0]    trial_low;
    logic [W-1:0]    rem_step;

    // rem_q < divisor, so the shifted trial stays below 2*divisor and the
    // W-bit subtraction wraps to the exact result.
    assign trial     = {rem_q, dvd_q[W-1]};
    assign trial_low = {rem_q[W-2:0], dvd_q[W-1]};
    assign rem_step  = (trial >= {1'b0, divisor_i}) ? trial_low - divisor_i : trial_low;

    assign done_o = busy_q && (cnt_q == CntLast);
    assign rem_o  = rem_step;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            dvd_d  = dividend_i;
            rem_d  = '0;
        end else if (busy_q) begin
            rem_d = rem_step;
            dvd_d = {dvd_q[W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
        end
    end

endmodule

// File: rtl/ita_mask_gen.sv
// QK attention-mask generator: IdxW-cycle PREP, then one N-lane mask beat per valid/ready handshake;
// outputs hold while mask_ready_i is low. ITA_MASK_PADDING_EN adds valid_len_i padding masking.
module ita_mask_gen
    import ita_mask_gen_pkg::*;
#(
    parameter int unsigned  M        = 64,
    parameter int unsigned  N        = 16,
    parameter int unsigned  MaxTiles = 16,
    localparam int unsigned IdxW     = $clog2(M * MaxTiles) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  mask_cfg_t       cfg_i,
`ifdef ITA_MASK_PADDING_EN
    input  logic [IdxW-1:0] valid_len_i,
`endif
    output logic [N-1:0]    mask_o,
    output logic            mask_valid_o,
    input  logic            mask_ready_i,
    output logic            busy_o,
    output logic            done_o
);

    localparam int unsigned Cg   = M / N;
    localparam int unsigned RitW = $clog2(M);
    localparam int unsigned CgW  = (Cg > 1) ? $clog2(Cg) : 1;
    localparam logic [RitW-1:0] RitLast = RitW'(M - 1);
    localparam logic [CgW-1:0]  CgLast  = CgW'(Cg - 1);
    localparam logic [IdxW-1:0] StepNum = IdxW'(M + N - 1);

    mask_state_e     state_q, state_d;
    mask_cfg_t       cfg_q, cfg_d;
    logic [IdxW-1:0] s_q, s_d;
    logic [IdxW-1:0] k_step_q, k_step_d;
    logic [IdxW-1:0] k_row_q, k_row_d;
    logic [IdxW-1:0] res_q, res_d;
    logic [RitW-1:0] rit_q, rit_d;
    logic [CgW-1:0]  cg_q, cg_d;
    logic [TileW-1:0] tx_q, tx_d;
    logic [TileW-1:0] ty_q, ty_d;
    logic            done_q, done_d;
`ifdef ITA_MASK_PADDING_EN
    logic [IdxW-1:0] vlen_q, vlen_d;
`endif

    logic            mod_start;
    logic            step_done, row_done;
    logic [IdxW-1:0] step_rem, row_rem;
    logic [IdxW-1:0] row_num;
    logic [TileW-1:0] t_last;
    logic            last_beat;

    // Distance from the last column of a tile row back to column 0, one row down.
    assign row_num = IdxW'(cfg_i.tile_s) * IdxW'(M) - IdxW'(N - 1);

    ita_mask_mod #(.W(IdxW)) u_mod_step (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (mod_start),
        .dividend_i (StepNum),
        .divisor_i  (s_q),
        .done_o     (step_done),
        .rem_o      (step_rem)
    );

    ita_mask_mod #(.W(IdxW)) u_mod_row (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (mod_start),
        .dividend_i (row_num),
        .divisor_i  (s_q),
        .done_o     (row_done),
        .rem_o      (row_rem)
    );

    assign t_last    = cfg_q.tile_s - TileW'(1);
    assign last_beat = (rit_q == RitLast) && (cg_q == CgLast) && (tx_q == t_last) && (ty_q == t_last);

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        s_d       = s_q;
        k_step_d  = k_step_q;
        k_row_d   = k_row_q;
        res_d     = res_q;
        rit_d     = rit_q;
        cg_d      = cg_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        done_d    = 1'b0;
        mod_start = 1'b0;
`ifdef ITA_MASK_PADDING_EN
        vlen_d    = vlen_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    cfg_d = cfg_i;
                    s_d   = (cfg_i.stride == '0) ? IdxW'(1) : IdxW'(cfg_i.stride);
                    res_d = '0;
                    rit_d = '0;
                    cg_d  = '0;
                    tx_d  = '0;
                    ty_d  = '0;
`ifdef ITA_MASK_PADDING_EN
                    vlen_d = valid_len_i;
`endif
                    if (cfg_i.tile_s == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = StPrep;
                        mod_start = 1'b1;
                    end
                end
            end
            StPrep: begin
                if (step_done && row_done) begin
                    k_step_d = step_rem;
                    k_row_d  = (row_rem == '0) ? '0 : s_q - row_rem;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (mask_ready_i) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (rit_q != RitLast) begin
                        rit_d = rit_q + 1'b1;
                        res_d = (res_q == '0) ? s_q - 1'b1 : res_q - 1'b1;
                    end else begin
                        rit_d = '0;
                        if (cg_q != CgLast) begin
                            cg_d  = cg_q + 1'b1;
                            res_d = mod_add(res_q, k_step_q, s_q);
                        end else begin
                            cg_d = '0;
                            if (tx_q != t_last) begin
                                tx_d  = tx_q + 1'b1;
                                res_d = mod_add(res_q, k_step_q, s_q);
                            end else begin
                                tx_d  = '0;
                                ty_d  = ty_q + 1'b1;
                                res_d = mod_add(res_q, k_row_q, s_q);
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cfg_q    <= '0;
            s_q      <= '0;
            k_step_q <= '0;
            k_row_q  <= '0;
            res_q    <= '0;
            rit_q    <= '0;
            cg_q     <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            done_q   <= 1'b0;
`ifdef ITA_MASK_PADDING_EN
            vlen_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            s_q      <= s_d;
            k_step_q <= k_step_d;
            k_row_q  <= k_row_d;
            res_q    <= res_d;
            rit_q    <= rit_d;
            cg_q     <= cg_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            done_q   <= done_d;
`ifdef ITA_MASK_PADDING_EN
            vlen_q   <= vlen_d;
`endif
        end
    end

    logic [IdxW-1:0]        col_base, row_pos, lane_col, lane_r;
    logic signed [IdxW:0]   lane_d, lane_ad, off_x, win_x;
    logic                   lane_far, lane_bit;
    logic [N-1:0]           mask_bits;

    assign col_base = IdxW'(tx_q) * IdxW'(M) + IdxW'(cg_q) * IdxW'(N);
    assign row_pos  = IdxW'(ty_q) * IdxW'(M) + IdxW'(rit_q);
    assign off_x    = (IdxW + 1)'(cfg_q.offset);
    assign win_x    = $signed({1'b0, cfg_q.window});

    // res_q tracks (col - row) mod S for lane 0; later lanes chain +1 mod S.
    always_comb begin
        mask_bits = '0;
        lane_r    = res_q;
        lane_col  = '0;
        lane_d    = '0;
        lane_ad   = '0;
        lane_far  = 1'b0;
        lane_bit  = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane_col = col_base + IdxW'(i);
            lane_d   = $signed({1'b0, lane_col}) - $signed({1'b0, row_pos});
            lane_ad  = (lane_d < 0) ? -lane_d : lane_d;
            lane_far = (lane_ad >= win_x);
            case (cfg_q.mode)
                MaskCausal:        lane_bit = (lane_d > off_x);
                MaskAntiCausal:    lane_bit = ((-lane_d) > off_x);
                MaskStrided:       lane_bit = (lane_r != '0);
                MaskWindow:        lane_bit = lane_far;
                MaskStridedWindow: lane_bit = (lane_r != '0) && lane_far;
                default:           lane_bit = 1'b0;
            endcase
`ifdef ITA_MASK_PADDING_EN
            mask_bits[i] = lane_bit || (lane_col >= vlen_q) || (row_pos >= vlen_q);
`else
            mask_bits[i] = lane_bit;
`endif
            lane_r = mod_add(lane_r, IdxW'(1), s_q);
        end
    end

    assign mask_o       = (state_q == StRun) ? mask_bits : '0;
    assign mask_valid_o = (state_q == StRun);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;

endmodule
